// File: rtl/shift_pkg.sv
// Shared definitions for the serial I/O chain sequencer.
//  - state_t : transaction sequencer states (2-bit encoding)
//  - clog2   : width helper for bit-index and counter registers (never returns less than 1)
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Shift-clock phase strobe for the serial chain sequencer.
// Ports:
//  clk    in  system clock
//  nreset in  asynchronous active-low reset
//  clr    in  restart the divider so the first tick comes DIV cycles later
//  tick   out high for one clk every DIV clk cycles
module shift_tick_gen
    import shift_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shift_chain_ctrl.sv
// Sequencer/arbiter for a 595-style output chain and a 165-style input chain that share
// one shift clock. CPU writes, CPU read requests and a periodic refresh are merged into
// full-chain transactions: parallel-load inputs, shift BITS bits out/in, latch outputs.
// Ports:
//  clk, nreset            system clock, asynchronous active-low reset
//  wr_valid/wr_data       output word write (MSB shifted first); wr_ready = no write pending
//  rd_req                 request a fresh input sample
//  rd_data/rd_valid       last captured input word; one-cycle update strobe
//  busy                   transaction in progress
//  sr_dout/sr_clk         serial data and shift clock to the chains
//  sr_latch               output storage latch (rising edge updates pins)
//  sr_load_n              input chain parallel load, active low
//  sr_din                 serial data from the input chain (already synchronised)
module shift_chain_ctrl
    import shift_pkg::*;
#(
    parameter int BITS    = 16,
    parameter int DIV     = 2,
    parameter int REFRESH = 1024
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            wr_valid,
    input  logic [BITS-1:0] wr_data,
    output logic            wr_ready,
    input  logic            rd_req,
    output logic [BITS-1:0] rd_data,
    output logic            rd_valid,
    output logic            busy,
    output logic            sr_dout,
    output logic            sr_clk,
    output logic            sr_latch,
    output logic            sr_load_n,
    input  logic            sr_din
);

    localparam int            BW       = clog2(BITS);
    localparam int            RW       = clog2((REFRESH > 1) ? REFRESH : 2);
    localparam logic [BW-1:0] BIT_MSB  = BW'(BITS - 1);
    localparam logic [RW-1:0] REF_LAST = (REFRESH > 0) ? RW'(REFRESH - 1) : '0;

    state_t          r_state;
    logic [BITS-1:0] r_shadow;
    logic [BITS-1:0] r_sreg;
    logic [BITS-1:0] r_rd_data;
    logic            r_rd_valid;
    logic            r_wr_pend;
    logic            r_rd_pend;
    logic [RW-1:0]   r_ref_cnt;
    logic [BW-1:0]   r_bit;
    logic            r_phase;
    logic            r_sr_clk;
    logic            r_sr_dout;
    logic            r_sr_latch;
    logic            r_sr_load_n;

    logic w_accept;
    logic w_ref_due;
    logic w_start;
    logic w_tick;

    assign w_accept  = wr_valid & ~r_wr_pend;
    assign w_ref_due = (REFRESH != 0) && (r_ref_cnt == REF_LAST);
    assign w_start   = (r_state == ST_IDLE) && (r_wr_pend || r_rd_pend || w_ref_due);

    assign wr_ready  = ~r_wr_pend;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign busy      = (r_state != ST_IDLE);
    assign sr_dout   = r_sr_dout;
    assign sr_clk    = r_sr_clk;
    assign sr_latch  = r_sr_latch;
    assign sr_load_n = r_sr_load_n;

    // Tick phase restarts at every transaction start so timing is identical per transaction.
    shift_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .nreset (nreset),
        .clr    (w_start),
        .tick   (w_tick)
    );

    // Request capture. Pending flags are consumed on the start edge; a request arriving on
    // that same edge stays pending and is served by the following transaction.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_shadow  <= '0;
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_ref_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_shadow <= wr_data;
            end
            if (w_start) begin
                r_wr_pend <= w_accept;
                r_rd_pend <= rd_req;
            end else begin
                if (w_accept) r_wr_pend <= 1'b1;
                if (rd_req)   r_rd_pend <= 1'b1;
            end
            // Refresh timer only advances while idle and restarts on any transaction.
            if (r_state == ST_IDLE) begin
                r_ref_cnt <= w_start ? '0 : r_ref_cnt + RW'(1);
            end
        end
    end

    // Transaction sequencer. r_sreg is shared: output bits leave from the MSB while input
    // bits enter at the LSB, so after BITS shifts it holds the captured input word.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= ST_IDLE;
            r_sreg      <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_bit       <= '0;
            r_phase     <= 1'b0;
            r_sr_clk    <= 1'b0;
            r_sr_dout   <= 1'b0;
            r_sr_latch  <= 1'b0;
            r_sr_load_n <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_LOAD;
                        r_sr_load_n <= 1'b0;
                        r_sreg      <= r_shadow;
                    end
                end
                ST_LOAD: begin
                    if (w_tick) begin
                        r_state     <= ST_SHIFT;
                        r_sr_load_n <= 1'b1;
                        r_bit       <= BIT_MSB;
                        r_phase     <= 1'b0;
                        r_sr_clk    <= 1'b0;
                        r_sr_dout   <= r_sreg[BITS-1];
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (!r_phase) begin
                            // Rising shift clock: sample input bit, advance output bit.
                            r_sr_clk <= 1'b1;
                            r_sreg   <= {r_sreg[BITS-2:0], sr_din};
                            r_phase  <= 1'b1;
                        end else begin
                            r_sr_clk  <= 1'b0;
                            r_phase   <= 1'b0;
                            r_sr_dout <= r_sreg[BITS-1];
                            if (r_bit == '0) begin
                                r_state    <= ST_LATCH;
                                r_sr_latch <= 1'b1;
                            end else begin
                                r_bit <= r_bit - BW'(1);
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (w_tick) begin
                        r_state    <= ST_IDLE;
                        r_sr_latch <= 1'b0;
                        r_rd_data  <= r_sreg;
                        r_rd_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
